ppu_pixel_mux: RTL and testbench

//  Final PPU pixel stage. Merges one background and one sprite pixel per pixel enable, resolves priority and clipping.

---
 rtl/ppu_pkg.sv | 42 ++++
 rtl/nes_system_palette_lut.sv | 13 +
 rtl/ppu_pixel_mux.sv | 173 +++++++++++++++++
 tb/tb_ppu_pixel_mux.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types, PPUMASK bit positions and the NES 2C02 system palette for the pixel output stage.
// Latency: n/a (package only).
// Backpressure: n/a.
package ppu_pkg;

    typedef logic [4:0] pal_addr_t;   // frame-palette RAM address
    typedef logic [5:0] nes_color_t;  // system colour index held in palette RAM

    // Palette entries are stored at 8 bits per channel; the pixel stage keeps the top RGB_W bits.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int MASK_GREY     = 0;
    localparam int MASK_BG_LEFT  = 1;
    localparam int MASK_SPR_LEFT = 2;
    localparam int MASK_SHOW_BG  = 3;
    localparam int MASK_SHOW_SPR = 4;
    localparam int MASK_EMPH_R   = 5;
    localparam int MASK_EMPH_G   = 6;
    localparam int MASK_EMPH_B   = 7;

    localparam logic [23:0] NES_SYSTEM_PALETTE [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    // A layer pixel is opaque when the layer is shown, its pattern is non-zero and it is not in a masked left column.
    function automatic logic pix_opaque(input logic show, input logic [1:0] pattern,
                                        input logic in_clip, input logic left_en);
        return show & (pattern != 2'b00) & ~(in_clip & ~left_en);
    endfunction

endpackage

// File: rtl/nes_system_palette_lut.sv
// Combinational ROM mapping a 6-bit NES colour index to 8-bit-per-channel RGB.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module nes_system_palette_lut
    import ppu_pkg::*;
(
    input  nes_color_t idx,
    output rgb_t       rgb
);

    assign rgb = rgb_t'(NES_SYSTEM_PALETTE[idx]);

endmodule

// File: rtl/ppu_pixel_mux.sv
// Final PPU pixel stage: bg/sprite priority and clipping, palette render-port read, colour-to-RGB mapping.
// Latency: 3 clock edges from pix_valid to rgb_valid; one pixel per cycle sustained.
// Backpressure: none; optional PPU_EMPHASIS_EN enables PPUMASK colour emphasis dimming.
module ppu_pixel_mux
    import ppu_pkg::*;
#(
    parameter int RGB_W        = 4,
    parameter int LEFT_CLIP_PX = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_valid,
    input  logic [7:0]         pix_x,
    input  logic [7:0]         pix_y,
    input  logic [3:0]         bg_pixel,
    input  logic [3:0]         spr_pixel,
    input  logic               spr_behind,
    input  logic               spr_is_zero,
    input  logic [7:0]         mask,
    input  logic               sp0_clear,
    output logic [4:0]         render_addr,
    output logic               render_rden,
    input  logic [7:0]         render_data,
    output logic [3*RGB_W-1:0] rgb_out,
    output logic               rgb_valid,
    output logic [7:0]         out_x,
    output logic [7:0]         out_y,
    output logic               sprite0_hit
);

    localparam logic [7:0] CLIP_X = 8'(LEFT_CLIP_PX);

    logic       in_clip;
    logic       bg_opaque;
    logic       spr_opaque;
    pal_addr_t  sel_addr;

    logic       s1_vld, s2_vld;
    logic [7:0] s1_x, s1_y, s2_x, s2_y;
    logic       s1_grey, s2_grey;

    nes_color_t       lut_idx;
    rgb_t             lut_rgb;
    logic [RGB_W-1:0] ch_r, ch_g, ch_b;
    logic [RGB_W-1:0] fin_r, fin_g, fin_b;

    assign in_clip    = pix_x < CLIP_X;
    assign bg_opaque  = pix_opaque(mask[MASK_SHOW_BG], bg_pixel[1:0], in_clip, mask[MASK_BG_LEFT]);
    assign spr_opaque = pix_opaque(mask[MASK_SHOW_SPR], spr_pixel[1:0], in_clip, mask[MASK_SPR_LEFT]);

    // Priority select: sprite wins unless it is behind an opaque background; nothing opaque reads the backdrop.
    always_comb begin
        sel_addr = 5'h00;
        if (spr_opaque && (!bg_opaque || !spr_behind)) begin
            sel_addr = {1'b1, spr_pixel};
        end else if (bg_opaque) begin
            sel_addr = {1'b0, bg_pixel};
        end
    end

    // S1: launch the palette read and capture the pixel's sideband; address holds across idle cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            render_addr <= 5'h00;
            render_rden <= 1'b0;
            s1_vld      <= 1'b0;
            s1_x        <= 8'h00;
            s1_y        <= 8'h00;
            s1_grey     <= 1'b0;
        end else begin
            render_rden <= pix_valid;
            s1_vld      <= pix_valid;
            if (pix_valid) begin
                render_addr <= sel_addr;
                s1_x        <= pix_x;
                s1_y        <= pix_y;
                s1_grey     <= mask[MASK_GREY];
            end
        end
    end

    // Sticky sprite-0 hit; a clear in the same cycle as a new hit takes precedence. Column 255 never hits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sprite0_hit <= 1'b0;
        end else if (sp0_clear) begin
            sprite0_hit <= 1'b0;
        end else if (pix_valid && bg_opaque && spr_opaque && spr_is_zero && (pix_x != 8'hFF)) begin
            sprite0_hit <= 1'b1;
        end
    end

    // S2: sideband waits one cycle while the palette RAM performs its read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld  <= 1'b0;
            s2_x    <= 8'h00;
            s2_y    <= 8'h00;
            s2_grey <= 1'b0;
        end else begin
            s2_vld  <= s1_vld;
            s2_x    <= s1_x;
            s2_y    <= s1_y;
            s2_grey <= s1_grey;
        end
    end

    // Greyscale keeps only the luma row of the colour index; palette bits 7:6 are not part of the colour.
    assign lut_idx = render_data[5:0] & (s2_grey ? 6'h30 : 6'h3F);

    nes_system_palette_lut u_lut (
        .idx (lut_idx),
        .rgb (lut_rgb)
    );

    assign ch_r = lut_rgb.r[7 -: RGB_W];
    assign ch_g = lut_rgb.g[7 -: RGB_W];
    assign ch_b = lut_rgb.b[7 -: RGB_W];

    logic unused_bits;
    assign unused_bits = ^{render_data[7:6], lut_rgb};

`ifdef PPU_EMPHASIS_EN
    logic [2:0] s1_emph, s2_emph;

    function automatic logic [RGB_W-1:0] dim(input logic [RGB_W-1:0] c);
        return c - (c >> 2);
    endfunction

    // Emphasis bits travel with the pixel so a mid-line PPUMASK write affects only later pixels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_emph <= 3'b000;
            s2_emph <= 3'b000;
        end else begin
            if (pix_valid) begin
                s1_emph <= mask[MASK_EMPH_B:MASK_EMPH_R];
            end
            s2_emph <= s1_emph;
        end
    end

    // With any emphasis active, every channel not emphasised is attenuated to 3/4.
    assign fin_r = (|s2_emph && !s2_emph[0]) ? dim(ch_r) : ch_r;
    assign fin_g = (|s2_emph && !s2_emph[1]) ? dim(ch_g) : ch_g;
    assign fin_b = (|s2_emph && !s2_emph[2]) ? dim(ch_b) : ch_b;
`else
    logic unused_emph;
    assign unused_emph = ^mask[MASK_EMPH_B:MASK_EMPH_R];

    assign fin_r = ch_r;
    assign fin_g = ch_g;
    assign fin_b = ch_b;
`endif

    // S3: register the final colour with its coordinates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_valid <= 1'b0;
            rgb_out   <= '0;
            out_x     <= 8'h00;
            out_y     <= 8'h00;
        end else begin
            rgb_valid <= s2_vld;
            if (s2_vld) begin
                rgb_out <= {fin_r, fin_g, fin_b};
                out_x   <= s2_x;
                out_y   <= s2_y;
            end
        end
    end

endmodule

// File: tb/tb_ppu_pixel_mux.sv
`timescale 1ns/1ps
module tb_ppu_pixel_mux;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_x = 8'h00;
    logic [7:0]  pix_y = 8'h00;
    logic [3:0]  bg_pixel = 4'h0;
    logic [3:0]  spr_pixel = 4'h0;
    logic        spr_behind = 1'b0;
    logic        spr_is_zero = 1'b0;
    logic [7:0]  mask = 8'h00;
    logic        sp0_clear = 1'b0;
    logic [4:0]  render_addr;
    logic        render_rden;
    logic [7:0]  render_data;
    logic [11:0] rgb_out;
    logic        rgb_valid;
    logic [7:0]  out_x;
    logic [7:0]  out_y;
    logic        sprite0_hit;

    typedef struct {
        logic [11:0] rgb;
        logic [7:0]  x;
        logic [7:0]  y;
    } exp_t;

    exp_t       rgb_q[$];
    logic [4:0] addr_q[$];
    exp_t       e;
    logic [7:0] ram [32];
    int         n_cmp = 0;
    int         n_err = 0;
    int         run_len = 0;
    int         max_run = 0;

`ifdef PPU_EMPHASIS_EN
    localparam logic [11:0] EMPH_RGB = 12'hFCC;
`else
    localparam logic [11:0] EMPH_RGB = 12'hFFF;
`endif

    ppu_pixel_mux #(.RGB_W(4), .LEFT_CLIP_PX(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .bg_pixel    (bg_pixel),
        .spr_pixel   (spr_pixel),
        .spr_behind  (spr_behind),
        .spr_is_zero (spr_is_zero),
        .mask        (mask),
        .sp0_clear   (sp0_clear),
        .render_addr (render_addr),
        .render_rden (render_rden),
        .render_data (render_data),
        .rgb_out     (rgb_out),
        .rgb_valid   (rgb_valid),
        .out_x       (out_x),
        .out_y       (out_y),
        .sprite0_hit (sprite0_hit)
    );

    always #5 clk = ~clk;

    // Palette RAM model: data appears the cycle after a read enable.
    always @(posedge clk) begin
        if (render_rden) render_data <= ram[render_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every read address and every output pixel against the queued expectations.
    always @(negedge clk) begin
        if (reset_n) begin
            if (render_rden) begin
                if (addr_q.size() == 0) check("addr_unexpected", 32'(render_rden), 32'd0);
                else check("render_addr", 32'(render_addr), 32'(addr_q.pop_front()));
            end
            if (rgb_valid) begin
                if (rgb_q.size() == 0) begin
                    check("rgb_unexpected", 32'(rgb_valid), 32'd0);
                end else begin
                    e = rgb_q.pop_front();
                    check("rgb_out", 32'(rgb_out), 32'(e.rgb));
                    check("out_x", 32'(out_x), 32'(e.x));
                    check("out_y", 32'(out_y), 32'(e.y));
                end
            end
            if (rgb_valid) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    task automatic send(input logic [3:0] bg, input logic [3:0] spr, input logic behind,
                        input logic zero, input logic [7:0] m, input logic [7:0] x,
                        input logic [4:0] ea, input logic [11:0] ergb);
        @(negedge clk);
        pix_valid   = 1'b1;
        bg_pixel    = bg;
        spr_pixel   = spr;
        spr_behind  = behind;
        spr_is_zero = zero;
        mask        = m;
        pix_x       = x;
        pix_y       = x + 8'd1;
        sp0_clear   = 1'b0;
        addr_q.push_back(ea);
        rgb_q.push_back('{ergb, x, 8'(x + 8'd1)});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sp0_clear = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'h0F;
        ram[5'h00] = 8'h2C;  // 00E8D8 -> 0ED
        ram[5'h02] = 8'h16;  // F83800 -> F30, grey -> idx 10 -> BBB
        ram[5'h05] = 8'h21;  // 3CBCFC -> 3BF
        ram[5'h06] = 8'h30;  // FCFCFC -> FFF
        ram[5'h11] = 8'h2A;  // 58D854 -> 5D5
        ram[5'h19] = 8'h3C;  // 00FCFC -> 0FF
        ram[5'h1B] = 8'hD6;  // high bits set, idx 16 -> F30

        #1;
        check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
        check("reset_rden", 32'(render_rden), 32'd0);
        check("reset_addr", 32'(render_addr), 32'd0);
        check("reset_rgb_out", 32'(rgb_out), 32'd0);
        check("reset_sp0", 32'(sprite0_hit), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        send(4'h6, 4'h0, 1'b0, 1'b0, 8'h08,  8'd20, 5'h06, 12'hFFF);
        send(4'h5, 4'hB, 1'b0, 1'b0, 8'h1E,  8'd50, 5'h1B, 12'hF30);
        send(4'h5, 4'hB, 1'b1, 1'b0, 8'h1E,  8'd51, 5'h05, 12'h3BF);
        send(4'h2, 4'h1, 1'b0, 1'b0, 8'h1C,  8'd3,  5'h11, 12'h5D5);
        send(4'h2, 4'h1, 1'b0, 1'b0, 8'h18,  8'd3,  5'h00, 12'h0ED);
        send(4'h2, 4'h0, 1'b0, 1'b0, 8'h09,  8'd30, 5'h02, 12'hBBB);
        send(4'h2, 4'h0, 1'b0, 1'b0, 8'h08,  8'd31, 5'h02, 12'hF30);
        send(4'h5, 4'hB, 1'b0, 1'b0, 8'h06,  8'd32, 5'h00, 12'h0ED);
        send(4'h6, 4'h0, 1'b0, 1'b0, 8'h28,  8'd33, 5'h06, EMPH_RGB);
        idle(5);

        max_run = 0;
        for (int i = 0; i < 10; i++) send(4'h6, 4'h0, 1'b0, 1'b0, 8'h08, 8'(40 + i), 5'h06, 12'hFFF);
        idle(6);
        check("b2b_run", 32'(max_run), 32'd10);

        // Sprite-0 hit set, hold, clear, column 255, clear racing a hit.
        send(4'h1, 4'h9, 1'b0, 1'b1, 8'h18, 8'd100, 5'h19, 12'h0FF);
        idle(1);
        check("sp0_set", 32'(sprite0_hit), 32'd1);
        idle(3);
        check("sp0_hold", 32'(sprite0_hit), 32'd1);
        check("addr_hold", 32'(render_addr), 32'h19);
        @(negedge clk);
        sp0_clear = 1'b1;
        idle(1);
        check("sp0_clear", 32'(sprite0_hit), 32'd0);
        send(4'h1, 4'h9, 1'b0, 1'b1, 8'h18, 8'd255, 5'h19, 12'h0FF);
        idle(1);
        check("sp0_x255", 32'(sprite0_hit), 32'd0);
        send(4'h1, 4'h9, 1'b0, 1'b1, 8'h18, 8'd100, 5'h19, 12'h0FF);
        sp0_clear = 1'b1;
        idle(1);
        check("sp0_clear_wins", 32'(sprite0_hit), 32'd0);
        idle(5);

        // Reset with pixels in flight.
        send(4'h1, 4'h9, 1'b0, 1'b1, 8'h18, 8'd100, 5'h19, 12'h0FF);
        send(4'h6, 4'h0, 1'b0, 1'b0, 8'h08, 8'd60, 5'h06, 12'hFFF);
        @(negedge clk);
        pix_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_rgb_valid", 32'(rgb_valid), 32'd0);
        check("midrst_rden", 32'(render_rden), 32'd0);
        check("midrst_sp0", 32'(sprite0_hit), 32'd0);
        addr_q.delete();
        rgb_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle(4);
        check("post_rst_no_valid", 32'(rgb_valid), 32'd0);
        send(4'h5, 4'hB, 1'b0, 1'b0, 8'h1E, 8'd70, 5'h1B, 12'hF30);
        idle(8);

        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("rgb_q_drained", 32'(rgb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
